// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: I/O register offsets and read-source tags.
package mmio_pkg;

  localparam logic [3:0] LED_OFF        = 4'h0;
  localparam logic [3:0] BTN_STATE_OFF  = 4'h1;
  localparam logic [3:0] BTN_EDGE_OFF   = 4'h2;
  localparam logic [3:0] CYCLE_OFF      = 4'h3;
  localparam logic [3:0] TIMER_OFF      = 4'h4;
  localparam logic [3:0] TIMER_CTRL_OFF = 4'h5;

  typedef enum logic [1:0] {RD_RAM, RD_IO, RD_NONE} rd_src_e;

endpackage

// File: rtl/btn_debounce.sv
// One-button debouncer: 2-flop synchronizer followed by a stability counter.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 750000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronized level differs from the accepted one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Data-port bridge: decodes RAM / 16-word I/O window / unmapped, uniform 1-cycle reads.
// Define MMIO_TIMER_EN to build the down-counter timer and its interrupt.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter int          ADDR_W          = 12,
  parameter logic [31:0] IO_BASE         = 32'h0000_F000,
  parameter int          LED_W           = 16,
  parameter int          BTN_W           = 4,
  parameter int          DEBOUNCE_CYCLES = 750000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [BTN_W-1:0]  btn_in,
  output logic [LED_W-1:0]  led_out,
  output logic              irq_out
);

  logic              ram_sel, io_sel, io_wr;
  logic [3:0]        off;
  logic [BTN_W-1:0]  btn_state, btn_prev, btn_edge, btn_clr;
  logic [31:0]       cycle_cnt;
  logic [DATA_W-1:0] io_rdata, io_rdata_q;
  rd_src_e           rd_src;

  assign ram_sel   = (cpu_addr >> ADDR_W) == 32'd0;
  assign io_sel    = cpu_addr[31:4] == IO_BASE[31:4];
  assign io_wr     = cpu_wren & io_sel;
  assign off       = cpu_addr[3:0];
  assign ram_wen   = cpu_wren & ram_sel;
  assign ram_addr  = cpu_addr[ADDR_W-1:0];
  assign ram_wdata = cpu_wdata;
  assign btn_clr   = (io_wr && off == BTN_EDGE_OFF) ? cpu_wdata[BTN_W-1:0] : '0;

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .din   (btn_in[g]),
      .dout  (btn_state[g])
    );
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;
  logic        expired, timer_ld, expire;

  assign timer_ld = io_wr && off == TIMER_OFF;
  // A load on the edge the count would hit zero cancels that expiry.
  assign expire   = (timer == 32'd1) && !timer_ld;
  assign irq_out  = expired;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      expired <= 1'b0;
    end else begin
      if (timer_ld)               timer <= 32'(cpu_wdata);
      else if (timer != 32'd0)    timer <= timer - 32'd1;
      if (expire)                 expired <= 1'b1;
      else if (io_wr && off == TIMER_CTRL_OFF && cpu_wdata[0]) expired <= 1'b0;
    end
  end
`else
  assign irq_out = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    case (off)
      LED_OFF:        io_rdata[LED_W-1:0] = led_out;
      BTN_STATE_OFF:  io_rdata[BTN_W-1:0] = btn_state;
      BTN_EDGE_OFF:   io_rdata[BTN_W-1:0] = btn_edge;
      CYCLE_OFF:      io_rdata = DATA_W'(cycle_cnt);
`ifdef MMIO_TIMER_EN
      TIMER_OFF:      io_rdata = DATA_W'(timer);
      TIMER_CTRL_OFF: io_rdata[0] = expired;
`endif
      default:        io_rdata = '0;
    endcase
  end

  // Read value is captured from pre-edge state, so same-edge stores are not visible yet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out    <= '0;
      btn_prev   <= '0;
      btn_edge   <= '0;
      cycle_cnt  <= '0;
      io_rdata_q <= '0;
      rd_src     <= RD_NONE;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      btn_prev   <= btn_state;
      btn_edge   <= (btn_edge & ~btn_clr) | (btn_state & ~btn_prev);
      io_rdata_q <= io_rdata;
      rd_src     <= ram_sel ? RD_RAM : (io_sel ? RD_IO : RD_NONE);
      if (io_wr && off == LED_OFF) led_out <= cpu_wdata[LED_W-1:0];
    end
  end

  always_comb begin
    case (rd_src)
      RD_RAM:  cpu_rdata = ram_rdata;
      RD_IO:   cpu_rdata = io_rdata_q;
      default: cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with a short debounce window.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [3:0]  btn_in;
  logic [15:0] led_out;
  logic        irq_out;

  logic [31:0] mem [4096];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] v1, v2;

  always #5 clk = ~clk;

  mmio_bridge #(.DEBOUNCE_CYCLES(8)) dut (
    .clock     (clk),
    .reset     (reset),
    .cpu_wren  (cpu_wren),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .btn_in    (btn_in),
    .led_out   (led_out),
    .irq_out   (irq_out)
  );

  // Synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_wren = 1'b1; cpu_addr = a; cpu_wdata = d;
    step();
    cpu_wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_wren = 1'b0; cpu_addr = a;
    step();
  endtask

  initial begin
    reset = 1'b1; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0; btn_in = '0;
    repeat (2) @(negedge clk);
    check("rst_led", {16'd0, led_out}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_irq", {31'd0, irq_out}, 32'd0);
    reset = 1'b0;

    // RAM store then load
    cpu_wren = 1'b1; cpu_addr = 32'h5; cpu_wdata = 32'hDEAD_BEEF; #1;
    check("ram_wen_store", {31'd0, ram_wen}, 32'd1);
    check("ram_addr", {20'd0, ram_addr}, 32'h5);
    step();
    cpu_wren = 1'b0; #1;
    check("ram_wen_pulse", {31'd0, ram_wen}, 32'd0);
    step();
    check("ram_load", cpu_rdata, 32'hDEAD_BEEF);

    // LED register
    cpu_wren = 1'b1; cpu_addr = 32'hF000; cpu_wdata = 32'h0001_ABCD; #1;
    check("led_no_ram_wen", {31'd0, ram_wen}, 32'd0);
    step();
    cpu_wren = 1'b0;
    check("led_out", {16'd0, led_out}, 32'h0000_ABCD);
    rd(32'hF000);
    check("led_read", cpu_rdata, 32'h0000_ABCD);

    // Unmapped store/load
    cpu_wren = 1'b1; cpu_addr = 32'h0002_0000; cpu_wdata = 32'h1234_5678; #1;
    check("unmapped_no_ram_wen", {31'd0, ram_wen}, 32'd0);
    step();
    rd(32'h0002_0000);
    check("unmapped_read", cpu_rdata, 32'd0);
    rd(32'h5);
    check("ram_intact", cpu_rdata, 32'hDEAD_BEEF);

    // Cycle counter: consecutive reads and wrap
    rd(32'hF003); v1 = cpu_rdata;
    step();       v2 = cpu_rdata;
    check("cycle_delta", v2 - v1, 32'd1);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    step();
    check("cycle_max", cpu_rdata, 32'hFFFF_FFFF);
    step();
    check("cycle_wrap", cpu_rdata, 32'd0);

    // Debounce: glitch rejected, held level accepted after 2+8 cycles
    cpu_addr = 32'hF001;
    btn_in[1] = 1'b1;
    repeat (5) step();
    btn_in[1] = 1'b0;
    repeat (12) step();
    check("btn_glitch", cpu_rdata, 32'd0);
    btn_in[1] = 1'b1;
    repeat (10) step();
    check("btn_state_early", cpu_rdata, 32'd0);
    step();
    check("btn_state", cpu_rdata, 32'd2);
    rd(32'hF002);
    check("btn_edge_set", cpu_rdata, 32'd2);
    wr(32'hF002, 32'd2);
    rd(32'hF002);
    check("btn_edge_w1c", cpu_rdata, 32'd0);
    rd(32'hF001);
    check("btn_state_hold", cpu_rdata, 32'd2);

`ifdef MMIO_TIMER_EN
    wr(32'hF004, 32'd3);
    check("timer_irq_t1", {31'd0, irq_out}, 32'd0);
    repeat (2) step();
    check("timer_irq_t3", {31'd0, irq_out}, 32'd0);
    step();
    check("timer_irq_set", {31'd0, irq_out}, 32'd1);
    rd(32'hF005);
    check("timer_ctrl_read", cpu_rdata, 32'd1);
    rd(32'hF004);
    check("timer_count_zero", cpu_rdata, 32'd0);
    wr(32'hF005, 32'd1);
    check("timer_irq_clr", {31'd0, irq_out}, 32'd0);
`else
    wr(32'hF004, 32'd3);
    repeat (4) step();
    check("no_timer_irq", {31'd0, irq_out}, 32'd0);
    rd(32'hF004);
    check("no_timer_read", cpu_rdata, 32'd0);
    wr(32'hF005, 32'd1);
    check("no_timer_irq2", {31'd0, irq_out}, 32'd0);
`endif

    // Asynchronous reset mid-debounce, then re-qualification
    rd(32'hF000);
    check("led_before_rst", cpu_rdata, 32'h0000_ABCD);
    btn_in = 4'b0011;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("arst_led", {16'd0, led_out}, 32'd0);
    check("arst_rdata", cpu_rdata, 32'd0);
    check("arst_irq", {31'd0, irq_out}, 32'd0);
    check("arst_ram_wen", {31'd0, ram_wen}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_addr = 32'hF001;
    repeat (10) step();
    check("requal_early", cpu_rdata, 32'd0);
    step();
    check("requal_state", cpu_rdata, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the processor data-memory port and the data RAM. Decodes each access to RAM, to a memory-mapped I/O window, or to unmapped space.
- The I/O window holds an LED output register, debounced button inputs with sticky press flags, and a free-running cycle counter.
- Every region has the same one-cycle read latency, so the processor sees one uniform synchronous memory.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 12, RAM word-address width; RAM occupies addresses 0 .. 2**ADDR_W-1
- IO_BASE, 32'h0000_F000, base word address of the 16-word I/O window; low 4 bits must be 0
- LED_W, 16, LED register width (LED_W <= DATA_W)
- BTN_W, 4, number of button inputs (BTN_W <= DATA_W)
- DEBOUNCE_CYCLES, 750000, stable cycles required to accept a button change (10 ms at 75 MHz)

Ports:
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_wren  in  1  processor store strobe
- cpu_addr  in  32  processor word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid one cycle after the address
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM synchronous read data (1-cycle latency)
- btn_in  in  BTN_W  raw, asynchronous button levels
- led_out  out  LED_W  LED register contents
- irq_out  out  1  timer-expired interrupt level

Behaviour:
- Decode is combinational from cpu_addr:
  - ram_sel = cpu_addr < 2**ADDR_W
  - io_sel = cpu_addr[31:4] == IO_BASE[31:4]
  - anything else is unmapped
- ram_addr = cpu_addr[ADDR_W-1:0] and ram_wdata = cpu_wdata, both passed through.
- ram_wen = cpu_wren & ram_sel.
- Stores to I/O take effect on the rising edge where cpu_wren=1 and io_sel=1. Stores to unmapped addresses are dropped.
- Reads:
  - At each edge, register rd_src (RAM / IO / NONE) and the I/O read value selected by cpu_addr[3:0].
  - cpu_rdata = ram_rdata when rd_src=RAM, the registered I/O value when rd_src=IO, 0 when NONE.
  - Latency is exactly 1 cycle in all cases. A read reflects register state before any same-edge write.
- I/O map (offset = cpu_addr[3:0]):
  - 0x0 LED: read/write, low LED_W bits; upper read bits are 0.
  - 0x1 BTN_STATE: read-only, debounced levels.
  - 0x2 BTN_EDGE: sticky press flags, write-1-to-clear.
  - 0x3 CYCLE: read-only 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
  - 0x4 TIMER and 0x5 TIMER_CTRL: see Optional Feature.
  - All other offsets read 0; writes to them are ignored.
- Debounce, per button:
  - Two-flop synchronizer, then a stability counter.
  - The counter resets whenever the synchronized input equals the debounced state, or changes during counting.
  - The debounced state flips after DEBOUNCE_CYCLES consecutive cycles of a differing input.
  - Total latency from a stable input change to BTN_STATE = 2 + DEBOUNCE_CYCLES cycles.
- BTN_EDGE bit sets on a 0->1 transition of the debounced state. If a set and a W1C clear land on the same edge, set wins.
- Reset values: led_out=0, BTN_STATE=0, BTN_EDGE=0, CYCLE=0, debounce counters=0, synchronizers=0, rd_src=NONE (cpu_rdata=0), TIMER=0, expired=0, irq_out=0.
- Reset asserted mid-operation clears everything immediately, including any pending debounce count. A debounced high level must be re-qualified after reset.

Optional Feature:
- Macro MMIO_TIMER_EN.
- Defined:
  - Writing TIMER (0x4) loads a 32-bit down-counter.
  - The counter decrements each cycle while nonzero.
  - On the 1->0 transition it sets the expired flag (TIMER_CTRL bit0). irq_out = expired.
  - Writing 1 to TIMER_CTRL bit0 clears expired. If a clear and an expiry land on the same edge, expiry wins.
  - A TIMER write on the same edge as a decrement: the load wins.
  - Reads of 0x4 return the current count.
- Undefined: offsets 0x4/0x5 read 0, writes are ignored, and irq_out is tied to 0. The port is always present.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants LED_OFF, BTN_STATE_OFF, BTN_EDGE_OFF, CYCLE_OFF, TIMER_OFF, TIMER_CTRL_OFF
  - the rd_src enum (RD_RAM, RD_IO, RD_NONE)
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES, 1-bit in/out), instantiated BTN_W times.

Test Plan:
- Store 32'hDEAD_BEEF to addr 0x005, then load 0x005 -> ram_wen pulses for one cycle; cpu_rdata=32'hDEAD_BEEF one cycle after the load address.
- Store 32'h0001_ABCD to 0xF000 -> led_out=16'hABCD; load 0xF000 -> 32'h0000_ABCD; ram_wen stays 0.
- Bench with DEBOUNCE_CYCLES=8:
  - btn_in[1] glitches high for 5 cycles -> BTN_STATE stays 0.
  - btn_in[1] held high -> BTN_STATE=2 after 10 cycles and BTN_EDGE=2.
  - Store 2 to 0xF002 -> BTN_EDGE=0.
- Load 0xF003 on two consecutive cycles -> values differ by exactly 1. Force the counter to 32'hFFFF_FFFF -> next read returns 0.
- Store to 0x2_0000 (unmapped), then load it -> no RAM write, cpu_rdata=0. Assert reset mid-debounce -> all outputs 0 with no clock edge.
- With MMIO_TIMER_EN, store 3 to 0xF004:
  - irq_out=1 three cycles later.
  - Store 1 to 0xF005 -> irq_out=0.
  - Without the macro, irq_out is never 1.
